// File: rtl/test_result_monitor_pkg.sv
// Shared definitions for the riscv-tests end-of-test monitor.
//
// riscv-tests gp encoding: on ECALL, gp == 1 means the test passed. Any other value is
// (failing_test_number << 1) | 1, so the failing test number is gp >> 1. gp == 0 means the
// test never reached a result write, which reports as test number 0.
package test_result_monitor_pkg;

  // State encoding shared with benches that decode the monitor state.
  localparam logic [2:0] MON_IDLE    = 3'd0;
  localparam logic [2:0] MON_RUN     = 3'd1;
  localparam logic [2:0] MON_PASS    = 3'd2;
  localparam logic [2:0] MON_FAIL    = 3'd3;
  localparam logic [2:0] MON_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = MON_IDLE,
    StRun     = MON_RUN,
    StPass    = MON_PASS,
    StFail    = MON_FAIL,
    StTimeout = MON_TIMEOUT
  } mon_state_e;

  // Raw ECALL instruction word (SYSTEM opcode, all other fields zero).
  localparam logic [31:0] ECALL_OPCODE = 32'h0000_0073;

  // Terminal states hold until reset.
  function automatic logic is_terminal(mon_state_e s);
    return (s == StPass) || (s == StFail) || (s == StTimeout);
  endfunction

endpackage

// File: rtl/test_result_monitor_sat.sv
// sat_counter: clearable up-counter that either saturates at all-ones or wraps.
// Clear has priority over enable.
module sat_counter #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear, else hold at all-ones when saturating, else increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (SATURATE && (&count_q)) begin
        count_d = count_q;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // Count register, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/test_result_monitor.sv
// test_result_monitor: snoops retire/writeback to detect the end of a riscv-tests run.
// Shadows gp, classifies ECALL as PASS/FAIL, and raises TIMEOUT from a watchdog.
// Optional feature: define RESULT_MON_INSTRET_EN to add the instret port and counter.
module test_result_monitor
  import test_result_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter logic [4:0]  GP_REG         = 5'd3,
  parameter logic [31:0] ECALL_INSN     = ECALL_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        retire_vld,
  input  logic [31:0] retire_insn,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_test,
  output logic [31:0] cycles
`ifdef RESULT_MON_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  // Wraps when the watchdog is disabled; never compared in that case.
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  mon_state_e  state_q, state_d;
  logic [31:0] gp_q, gp_d;
  logic [30:0] fail_q, fail_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        cnt_clear;
  logic        cyc_en;

  logic        gp_wr;
  logic        ecall;
  logic [31:0] eff_gp;
  logic        timeout_hit;

  // x0 is hardwired, so a write with rd==0 never changes gp even if GP_REG is 0.
  assign gp_wr       = wb_en && (wb_rd == GP_REG) && (wb_rd != 5'd0);
  assign ecall       = retire_vld && (retire_insn == ECALL_INSN);
  // Forward a same-cycle gp write so the ECALL sees the final result value.
  assign eff_gp      = gp_wr ? wb_data : gp_q;
  assign timeout_hit = TimeoutEn && (cycles == TimeoutLast);

  // Next-state, shadow gp, failure code and registered output decode.
  always_comb begin
    state_d   = state_q;
    gp_d      = gp_q;
    fail_d    = fail_q;
    cnt_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          gp_d      = '0;
          cnt_clear = 1'b1;
        end
      end
      StRun: begin
        if (start) begin
          // Restart in place.
          gp_d      = '0;
          cnt_clear = 1'b1;
        end else begin
          if (gp_wr) begin
            gp_d = wb_data;
          end
          // ECALL has priority over the watchdog in the same cycle.
          if (ecall) begin
            if (eff_gp == 32'd1) begin
              state_d = StPass;
            end else begin
              state_d = StFail;
              fail_d  = eff_gp[31:1];
            end
          end else if (timeout_hit) begin
            state_d = StTimeout;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    done_d = is_terminal(state_d);
    pass_d = (state_d == StPass);
  end

  // State and output registers, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gp_q    <= '0;
      fail_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gp_q    <= gp_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // cycles freezes on the transition out of RUN, so it reports the last RUN cycle index.
  assign cyc_en = (state_q == StRun) && (state_d == StRun);

  sat_counter #(
    .WIDTH    (32),
    .SATURATE (1'b1)
  ) u_cycles (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cyc_en),
    .count  (cycles)
  );

`ifdef RESULT_MON_INSTRET_EN
  logic ret_en;

  // Counts every retire in RUN, including the terminating ECALL.
  assign ret_en = (state_q == StRun) && retire_vld;

  sat_counter #(
    .WIDTH    (32),
    .SATURATE (1'b0)
  ) u_instret (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (ret_en),
    .count  (instret)
  );
`endif

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_test = fail_q;

endmodule
